// File: rtl/ppe_grant_dec.sv
// Grant-side decoder for the registered programmable priority encoder.
// Registers the encoder winner as a one-hot grant and holds it until the requester handshakes.
// On release it returns the rotated pointer to the encoder's P_enc input.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   enc_value, enc_valid              encoder result
//   ptr_out                           rotated priority pointer
//   grant, gnt_idx, gnt_valid         grant outputs
//   gnt_ready                         requester accept
//   gnt_timeout                       timeout pulse (PPE_DEC_TIMEOUT_EN only)
// Optional feature: PPE_DEC_TIMEOUT_EN adds a grant timeout.
module ppe_grant_dec #(
  parameter int W       = 1024,
  parameter int LOG2W   = 10,
  parameter int ENC_LAT = 2,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LOG2W-1:0] enc_value,
  input  logic             enc_valid,
  output logic [LOG2W-1:0] ptr_out,
  output logic [W-1:0]     grant,
  output logic [LOG2W-1:0] gnt_idx,
  output logic             gnt_valid,
  input  logic             gnt_ready
`ifdef PPE_DEC_TIMEOUT_EN
  ,
  output logic             gnt_timeout
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    FLUSH
  } state_t;

  localparam int CW = (ENC_LAT > 0) ? $clog2(ENC_LAT + 1) : 1;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [W-1:0]     r_grant, w_grant_nxt;
  logic [LOG2W-1:0] r_idx, w_idx_nxt;
  logic             r_valid, w_valid_nxt;
  logic [LOG2W-1:0] r_ptr, w_ptr_nxt;
  logic             w_hs;
  logic             w_expire;

  assign w_hs = (r_state == GRANT) && r_valid && gnt_ready;

`ifdef PPE_DEC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_wait, w_wait_nxt;
  logic          r_to;

  // Expire on the TIMEOUT-th GRANT edge without a handshake;
  // a simultaneous handshake takes precedence.
  assign w_expire = (r_state == GRANT) && !w_hs &&
                    (r_wait == TW'(TIMEOUT - 1));

  always_comb begin
    w_wait_nxt = r_wait;
    if (r_state == IDLE && enc_valid)
      w_wait_nxt = '0;
    else if (r_state == GRANT && !w_hs)
      w_wait_nxt = r_wait + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= '0;
      r_to   <= 1'b0;
    end else begin
      r_wait <= w_wait_nxt;
      r_to   <= w_expire;
    end
  end

  assign gnt_timeout = r_to;
`else
  assign w_expire = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant_nxt = r_grant;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_valid;
    w_ptr_nxt   = r_ptr;
    unique case (r_state)
      IDLE: begin
        if (enc_valid) begin
          w_grant_nxt            = '0;
          w_grant_nxt[enc_value] = 1'b1;
          w_idx_nxt              = enc_value;
          w_valid_nxt            = 1'b1;
          w_state_nxt            = GRANT;
        end
      end
      GRANT: begin
        if (w_hs || w_expire) begin
          w_grant_nxt = '0;
          w_valid_nxt = 1'b0;
          // Natural LOG2W-bit wrap gives modulo W
          w_ptr_nxt   = r_idx + 1'b1;
          if (ENC_LAT == 0) begin
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt   = CW'(ENC_LAT);
            w_state_nxt = FLUSH;
          end
        end
      end
      FLUSH: begin
        // Drop results computed with the stale pointer
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == CW'(1))
          w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_grant <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_grant <= w_grant_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign grant     = r_grant;
  assign gnt_idx   = r_idx;
  assign gnt_valid = r_valid;
  assign ptr_out   = r_ptr;

endmodule

// File: tb/tb_ppe_grant_dec.sv
// Testbench for ppe_grant_dec: scoreboard of grant/release events
// checked against a transaction-level reference model.
module tb_ppe_grant_dec;
  localparam int W   = 1024;
  localparam int LW  = 10;
  localparam int LAT = 2;
  localparam int TO  = 4;
`ifdef PPE_DEC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [LW-1:0] enc_value = '0;
  logic          enc_valid = 1'b0;
  logic [LW-1:0] ptr_out;
  logic [W-1:0]  grant;
  logic [LW-1:0] gnt_idx;
  logic          gnt_valid;
  logic          gnt_ready = 1'b0;
  logic          gnt_timeout;

  ppe_grant_dec #(
    .W(W), .LOG2W(LW), .ENC_LAT(LAT), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enc_value(enc_value),
    .enc_valid(enc_valid),
    .ptr_out(ptr_out),
    .grant(grant),
    .gnt_idx(gnt_idx),
    .gnt_valid(gnt_valid),
    .gnt_ready(gnt_ready)
`ifdef PPE_DEC_TIMEOUT_EN
    ,
    .gnt_timeout(gnt_timeout)
`endif
  );

`ifndef PPE_DEC_TIMEOUT_EN
  assign gnt_timeout = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int c;
    int v;
    bit to;
  } ev_t;

  ev_t gq[$];
  ev_t rq[$];

  // Reference model: one outstanding grant, pointer, earliest accept cycle
  bit m_hold = 1'b0;
  int m_idx  = 0;
  int m_ptr  = 0;
  int m_acc  = 0;
  int m_wait = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic m_release(input int s, input bit to);
    m_hold = 1'b0;
    m_ptr  = (m_idx + 1) % W;
    m_acc  = s + LAT + 1;
    rq.push_back('{s, m_ptr, to});
  endtask

  task automatic model(input bit ev, input int v, input bit rd, input int s);
    if (m_hold) begin
      if (rd) begin
        m_release(s, 1'b0);
      end else begin
        m_wait++;
        if (TO_EN && m_wait == TO)
          m_release(s, 1'b1);
      end
    end else if (ev && s >= m_acc) begin
      m_hold = 1'b1;
      m_idx  = v;
      m_wait = 0;
      gq.push_back('{s, v, 1'b0});
    end
  endtask

  task automatic step(input bit ev, input logic [LW-1:0] v, input bit rd);
    enc_valid = ev;
    enc_value = v;
    gnt_ready = rd;
    @(posedge clk);
    #1;
    model(ev, int'(v), rd, cyc);
  endtask

  task automatic model_reset();
    m_hold = 1'b0;
    m_ptr  = 0;
    m_acc  = 0;
    m_wait = 0;
  endtask

  // Monitor
  bit           prev_v = 1'b0;
  int           held = 0;
  ev_t          me;
  logic [W-1:0] evec;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (gnt_valid && !prev_v) begin
        if (gq.size() == 0) begin
          chk("spurious_grant", 64'd1, 64'd0);
        end else begin
          me = gq.pop_front();
          chk("grant_cycle", cyc, me.c);
          chk("gnt_idx", gnt_idx, me.v);
          evec = '0;
          evec[me.v] = 1'b1;
          chk("grant_vec", grant === evec, 64'd1);
          held = me.v;
        end
      end else if (gnt_valid) begin
        chk("idx_hold", gnt_idx, held);
      end
      if (!gnt_valid && prev_v) begin
        if (rq.size() == 0) begin
          chk("spurious_release", 64'd1, 64'd0);
        end else begin
          me = rq.pop_front();
          chk("release_cycle", cyc, me.c);
          chk("release_ptr", ptr_out, me.v);
          chk("timeout_pulse", gnt_timeout, me.to);
        end
      end else begin
        chk("timeout_quiet", gnt_timeout, 64'd0);
      end
      chk("grant_iff_valid", grant != '0, gnt_valid);
      chk("grant_onehot0", $onehot0(grant), 64'd1);
      chk("ptr_out", ptr_out, m_ptr);
      prev_v = gnt_valid;
    end
  end

  initial begin
    // Reset before any clock edge
    #2;
    chk("rst_grant", grant != '0, 64'd0);
    chk("rst_valid", gnt_valid, 64'd0);
    chk("rst_idx", gnt_idx, 64'd0);
    chk("rst_ptr", ptr_out, 64'd0);
    chk("rst_timeout", gnt_timeout, 64'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) step(1'b0, '0, 1'b0);

    // Basic grant, handshake, flush
    step(1'b1, 10'd5, 1'b1);
    step(1'b1, 10'd8, 1'b1);
    step(1'b1, 10'd8, 1'b0);
    step(1'b1, 10'd8, 1'b0);
    step(1'b1, 10'd7, 1'b0);
    step(1'b0, '0, 1'b1);
    repeat (LAT + 1) step(1'b0, '0, 1'b0);

    // Backpressure with toggling encoder input
    step(1'b1, 10'd9, 1'b0);
    for (int i = 0; i < 10; i++)
      step(1'b1, LW'(i * 37), 1'b0);
    step(1'b0, '0, 1'b1);
    repeat (LAT + 1) step(1'b0, '0, 1'b0);

    // Wrap at W-1
    step(1'b1, 10'd1023, 1'b1);
    step(1'b0, '0, 1'b1);
    repeat (LAT + 1) step(1'b0, '0, 1'b0);

    // Reset mid-GRANT
    step(1'b1, 10'd20, 1'b0);
    step(1'b0, '0, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    enc_valid = 1'b0;
    #1;
    chk("midrst_grant", grant != '0, 64'd0);
    chk("midrst_valid", gnt_valid, 64'd0);
    chk("midrst_ptr", ptr_out, 64'd0);
    model_reset();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    step(1'b1, 10'd33, 1'b0);
    step(1'b0, '0, 1'b1);
    repeat (LAT + 1) step(1'b0, '0, 1'b0);

`ifdef PPE_DEC_TIMEOUT_EN
    // Timeout with requester stalled
    step(1'b1, 10'd3, 1'b0);
    repeat (TO + LAT + 2) step(1'b0, '0, 1'b0);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, LW'($urandom_range(0, W - 1)),
           $urandom_range(0, 9) < 4);

    // Drain
    repeat (10) step(1'b0, '0, 1'b1);
    @(negedge clk);
    #1;
    chk("grant_q_empty", gq.size(), 64'd0);
    chk("release_q_empty", rq.size(), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
